nios_soc_spi_slave: RTL and testbench

- SPI slave peripheral for the Nios SoC: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- Lets the FPGA act as the far end of an SPI link driven by an external or on-chip SPI master.
- Exposes a memory-mapped register port with the same two-cycle strobe timing and status/control bit layout as the SoC's existing SPI master, so the same driver style applies.
- All SPI inputs are asynchronous to clk and are oversampled.

---
 rtl/nios_soc_spi_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_nios_soc_spi_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_soc_spi_slave.sv
// nios_soc_spi_slave
//   SPI slave (mode 0, MSB first, 8-bit frames) with a memory-mapped register
//   port whose strobe timing and status/control layout mirror the SoC SPI
//   master. SCLK, SS_n and MOSI are asynchronous and oversampled on clk.
//
// Ports
//   clk, reset_n          system clock, async active-low reset
//   mem_addr              register address (0 rx, 1 tx, 2 status, 3 control)
//   data_from_cpu         write data
//   data_to_cpu           registered read data
//   read_n, write_n       active-low access strobes, qualified by spi_select
//   SCLK, SS_n, MOSI      SPI inputs from the master
//   MISO, MISO_oe         SPI output and its enable (high while a frame is active)
//   irq                   registered interrupt
//   dataavailable         RRDY
//   readyfordata          TRDY
module nios_soc_spi_slave #(
  parameter logic [7:0] FILL_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_e;

  localparam logic [15:0] CTRL_MASK = 16'h01D8;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_prev_q, ss_prev_q;
  logic sclk_rise_q, sclk_fall_q, ss_rise_q, ss_fall_q, mosi_q;

  // Frame and register state
  state_e      state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_in_q, shift_in_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [7:0]  rx_holding_q, rx_holding_d;
  logic [7:0]  tx_holding_q, tx_holding_d;
  logic        primed_q, primed_d;
  logic        rrdy_q, rrdy_d;
  logic        roe_q, roe_d;
  logic        toe_q, toe_d;
  logic        armed_q, armed_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic        irq_q, irq_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rd_strobe_q, wr_strobe_q;

  logic        p1_rd, p1_wr;
  logic        load_ev, byte_done, tx_wr, e_bit, tmt;
  logic [15:0] status_w;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign p1_rd = ~rd_strobe_q & spi_select & ~read_n;
  assign p1_wr = ~wr_strobe_q & spi_select & ~write_n;

  assign e_bit    = roe_q | toe_q;
  assign tmt      = (state_q != ST_ACTIVE) & ~primed_q;
  assign status_w = {7'b0, e_bit, rrdy_q, ~primed_q, tmt, toe_q, roe_q, 3'b0};

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_in_d   = shift_in_q;
    shift_out_d  = shift_out_q;
    rx_holding_d = rx_holding_q;
    tx_holding_d = tx_holding_q;
    primed_d     = primed_q;
    rrdy_d       = rrdy_q;
    roe_d        = roe_q;
    toe_d        = toe_q;
    ctrl_d       = ctrl_q;
    load_ev      = 1'b0;
    byte_done    = 1'b0;
    tx_wr        = wr_strobe_q && (mem_addr == 3'd1);

    // settle_q keeps the reset value of the SS_n synchronizer from arming
    // the slave: only a real sample of SS_n high counts.
    armed_d = armed_q | (settle_q[SYNC_STAGES-1] & ss_s);

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_q && armed_q) begin
          state_d  = ST_ACTIVE;
          bitcnt_d = 4'd0;
          load_ev  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise_q) begin
          state_d  = ST_IDLE;
          bitcnt_d = 4'd0;
        end else if (sclk_rise_q && (bitcnt_q < 4'd8)) begin
          shift_in_d = {shift_in_q[6:0], mosi_q};
          bitcnt_d   = bitcnt_q + 4'd1;
          byte_done  = (bitcnt_q == 4'd7);
        end else if (sclk_fall_q) begin
          if (bitcnt_q == 4'd8) begin
            bitcnt_d = 4'd0;
            load_ev  = 1'b1;
          end else begin
            shift_out_d = {shift_out_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_ev) begin
      shift_out_d = primed_q ? tx_holding_q : FILL_BYTE;
      primed_d    = 1'b0;
    end

    // Clears first so that hardware sets below take priority.
    if (wr_strobe_q && (mem_addr == 3'd2)) begin
      roe_d  = 1'b0;
      toe_d  = 1'b0;
      rrdy_d = 1'b0;
    end
    if (rd_strobe_q && (mem_addr == 3'd0)) rrdy_d = 1'b0;

    // A load in the same cycle frees the entry, so the new write is kept.
    if (tx_wr) begin
      if (~primed_q | load_ev) begin
        tx_holding_d = data_from_cpu[7:0];
        primed_d     = 1'b1;
      end else begin
        toe_d = 1'b1;
      end
    end

    if (byte_done) begin
      rx_holding_d = {shift_in_q[6:0], mosi_q};
      rrdy_d       = 1'b1;
      if (rrdy_q) roe_d = 1'b1;
    end

    if (wr_strobe_q && (mem_addr == 3'd3)) ctrl_d = data_from_cpu & CTRL_MASK;

    irq_d = (e_bit & ctrl_q[8]) | (rrdy_q & ctrl_q[7]) | (~primed_q & ctrl_q[6])
          | (toe_q & ctrl_q[4]) | (roe_q & ctrl_q[3]);

    case (mem_addr)
      3'd0:    rdata_d = {8'h00, rx_holding_q};
      3'd2:    rdata_d = status_w;
      3'd3:    rdata_d = ctrl_q;
      default: rdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q  <= '0;
      ss_sync_q    <= '1;
      mosi_sync_q  <= '0;
      settle_q     <= '0;
      sclk_prev_q  <= 1'b0;
      ss_prev_q    <= 1'b1;
      sclk_rise_q  <= 1'b0;
      sclk_fall_q  <= 1'b0;
      ss_rise_q    <= 1'b0;
      ss_fall_q    <= 1'b0;
      mosi_q       <= 1'b0;
      state_q      <= ST_IDLE;
      bitcnt_q     <= 4'd0;
      shift_in_q   <= 8'h00;
      shift_out_q  <= 8'h00;
      rx_holding_q <= 8'h00;
      tx_holding_q <= 8'h00;
      primed_q     <= 1'b0;
      rrdy_q       <= 1'b0;
      roe_q        <= 1'b0;
      toe_q        <= 1'b0;
      armed_q      <= 1'b0;
      ctrl_q       <= 16'h0000;
      irq_q        <= 1'b0;
      rdata_q      <= 16'h0000;
      rd_strobe_q  <= 1'b0;
      wr_strobe_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q    <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      settle_q     <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q  <= sclk_s;
      ss_prev_q    <= ss_s;
      // Edges are registered and acted on in the following cycle.
      sclk_rise_q  <= sclk_s & ~sclk_prev_q;
      sclk_fall_q  <= ~sclk_s & sclk_prev_q;
      ss_rise_q    <= ss_s & ~ss_prev_q;
      ss_fall_q    <= ~ss_s & ss_prev_q;
      mosi_q       <= mosi_s;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_in_q   <= shift_in_d;
      shift_out_q  <= shift_out_d;
      rx_holding_q <= rx_holding_d;
      tx_holding_q <= tx_holding_d;
      primed_q     <= primed_d;
      rrdy_q       <= rrdy_d;
      roe_q        <= roe_d;
      toe_q        <= toe_d;
      armed_q      <= armed_d;
      ctrl_q       <= ctrl_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
      rd_strobe_q  <= p1_rd;
      wr_strobe_q  <= p1_wr;
    end
  end

  assign data_to_cpu   = rdata_q;
  assign MISO          = (state_q == ST_ACTIVE) & shift_out_q[7];
  assign MISO_oe       = (state_q == ST_ACTIVE);
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = ~primed_q;

endmodule

// File: tb/tb_nios_soc_spi_slave.sv
// Directed bench for nios_soc_spi_slave: a bit-banged SPI master at clk/20
// plus a two-cycle CPU register port driver; expected values are hand-computed.
module tb_nios_soc_spi_slave;

  logic        clk;
  logic        reset_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        read_n, write_n, spi_select;
  logic        SCLK, SS_n, MOSI;
  logic        MISO, MISO_oe, irq, dataavailable, readyfordata;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mb, mb2;
  logic [15:0] rd;

  nios_soc_spi_slave #(.FILL_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr      (mem_addr),
    .data_from_cpu (data_from_cpu),
    .data_to_cpu   (data_to_cpu),
    .read_n        (read_n),
    .write_n       (write_n),
    .spi_select    (spi_select),
    .SCLK          (SCLK),
    .SS_n          (SS_n),
    .MOSI          (MOSI),
    .MISO          (MISO),
    .MISO_oe       (MISO_oe),
    .irq           (irq),
    .dataavailable (dataavailable),
    .readyfordata  (readyfordata)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling clk edge.
  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
    repeat (2) @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
    repeat (2) @(negedge clk);
    d = data_to_cpu;
    spi_select = 1'b0; read_n = 1'b1;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      repeat (10) @(negedge clk);
      miso_byte = {miso_byte[6:0], MISO};
      SCLK = 1'b1;
      repeat (10) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] tx, output logic [7:0] miso_byte);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(tx, 8, miso_byte);
    repeat (10) @(negedge clk);
    SS_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    read_n = 1'b1; write_n = 1'b1; spi_select = 1'b0;
    mem_addr = 3'd0; data_from_cpu = 16'h0000;
    repeat (5) @(negedge clk);
    check_val("rst_data_to_cpu", data_to_cpu, 16'h0000);
    check_val("rst_miso", {15'b0, MISO}, 16'h0000);
    check_val("rst_miso_oe", {15'b0, MISO_oe}, 16'h0000);
    check_val("rst_irq", {15'b0, irq}, 16'h0000);
    check_val("rst_rrdy", {15'b0, dataavailable}, 16'h0000);
    check_val("rst_trdy", {15'b0, readyfordata}, 16'h0001);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    cpu_read(3'd2, rd);
    check_val("rst_status", rd, 16'h0060);

    // Primed TX 0x3C, receive 0xA5
    cpu_write(3'd1, 16'h003C);
    check_val("t1_trdy_low", {15'b0, readyfordata}, 16'h0000);
    spi_frame(8'hA5, mb);
    check_val("t1_miso", {8'h00, mb}, 16'h003C);
    check_val("t1_rrdy", {15'b0, dataavailable}, 16'h0001);
    check_val("t1_trdy", {15'b0, readyfordata}, 16'h0001);
    cpu_read(3'd0, rd);
    check_val("t1_rx", rd, 16'h00A5);
    check_val("t1_rrdy_clr", {15'b0, dataavailable}, 16'h0000);

    // Two bytes under one SS_n, nothing primed; second byte overruns
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(8'h12, 8, mb);
    spi_bits(8'h34, 8, mb2);
    repeat (10) @(negedge clk);
    SS_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("t2_miso0", {8'h00, mb}, 16'h00FF);
    check_val("t2_miso1", {8'h00, mb2}, 16'h00FF);
    // E, RRDY, TRDY, TMT, ROE set
    cpu_read(3'd2, rd);
    check_val("t2_status", rd, 16'h01E8);
    cpu_write(3'd2, 16'hFFFF);
    cpu_read(3'd2, rd);
    check_val("t2_status_clr", rd, 16'h0060);
    cpu_read(3'd0, rd);
    check_val("t2_rx", rd, 16'h0034);

    // Aborted frame after 5 rises, then a full frame
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    check_val("t3_oe_active", {15'b0, MISO_oe}, 16'h0001);
    spi_bits(8'hFF, 5, mb);
    repeat (10) @(negedge clk);
    SS_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("t3_rrdy_abort", {15'b0, dataavailable}, 16'h0000);
    check_val("t3_oe_abort", {15'b0, MISO_oe}, 16'h0000);
    spi_frame(8'h81, mb);
    cpu_read(3'd0, rd);
    check_val("t3_rx", rd, 16'h0081);

    // TX overrun with iTOE enabled
    cpu_write(3'd3, 16'h0010);
    cpu_read(3'd3, rd);
    check_val("t4_ctrl", rd, 16'h0010);
    cpu_write(3'd1, 16'h00C3);
    check_val("t4_trdy_low", {15'b0, readyfordata}, 16'h0000);
    cpu_write(3'd1, 16'h005A);
    check_val("t4_irq_before", {15'b0, irq}, 16'h0000);
    @(negedge clk);
    check_val("t4_irq_after", {15'b0, irq}, 16'h0001);
    cpu_read(3'd2, rd);
    check_val("t4_status", rd, 16'h0110);
    spi_frame(8'h00, mb);
    check_val("t4_miso", {8'h00, mb}, 16'h00C3);
    cpu_write(3'd2, 16'h0000);
    @(negedge clk);
    check_val("t4_irq_clr", {15'b0, irq}, 16'h0000);
    cpu_read(3'd2, rd);
    check_val("t4_status_clr", rd, 16'h0060);
    cpu_write(3'd3, 16'h0000);

    // Reset in mid-frame, released while SS_n is still low
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(8'hE0, 3, mb);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    spi_bits(8'hFF, 8, mb);
    repeat (10) @(negedge clk);
    check_val("t5_rrdy_none", {15'b0, dataavailable}, 16'h0000);
    check_val("t5_oe_none", {15'b0, MISO_oe}, 16'h0000);
    SS_n = 1'b1;
    repeat (10) @(negedge clk);
    spi_frame(8'h5A, mb);
    check_val("t5_rrdy", {15'b0, dataavailable}, 16'h0001);
    cpu_read(3'd0, rd);
    check_val("t5_rx", rd, 16'h005A);

    // Status write lands in the same cycle the byte completes
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(8'h96, 7, mb);
    MOSI = 1'b0;
    repeat (10) @(negedge clk);
    SCLK = 1'b1;
    repeat (2) @(negedge clk);
    cpu_write(3'd2, 16'h0000);
    repeat (8) @(negedge clk);
    SCLK = 1'b0;
    repeat (10) @(negedge clk);
    SS_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("t6_rrdy_wins", {15'b0, dataavailable}, 16'h0001);
    cpu_read(3'd2, rd);
    check_val("t6_status", rd, 16'h00E0);
    cpu_read(3'd0, rd);
    check_val("t6_rx", rd, 16'h0096);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
